// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the two's-complement sign-correction helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Widest value the sign-correction helper handles (2*WIDTH for WIDTH <= 64).
    localparam int FIX_BITS = 128;

    // Conditionally negate; callers zero-extend in and truncate out, which is
    // exact because negation modulo 2^N only depends on the low N bits.
    function automatic logic [FIX_BITS-1:0] cond_neg(input logic [FIX_BITS-1:0] v,
                                                     input logic                neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared radix-2 iteration datapath: a 2*WIDTH accumulator that performs one
// shift-add multiply step or one restoring shift-subtract divide step per enable.
// Both modes load {0, a}; after WIDTH steps the accumulator holds the product,
// or {remainder, quotient} for division.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_diff;

    // Next accumulator value for one multiply or divide step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_next  = acc_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial[WIDTH-1:0] - b_q;
        if (mode_div) begin
            if (div_trial >= {1'b0, b_q}) begin
                acc_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Accumulator and divisor/multiplier registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// MULT*/DIV* take WIDTH+1 cycles (WIDTH iteration steps plus one sign-fix
// cycle); MTHI/MTLO write in a single cycle. Issue is ignored while busy.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    localparam int PW = 2 * WIDTH;

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               accept_op;
    logic               accept_mtx;
    logic               iter_step;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes and result signs; unsigned ops pass raw values.
    always_comb begin
        signed_op = ~op[0];
        sign_a    = signed_op & rs_val[WIDTH-1];
        sign_b    = signed_op & rt_val[WIDTH-1];
        a_mag     = sign_a ? (~rs_val + 1'b1) : rs_val;
        b_mag     = sign_b ? (~rt_val + 1'b1) : rt_val;
    end

    // Sign correction applied in the FIX cycle.
    always_comb begin
        prod_fix = PW'(cond_neg(FIX_BITS'(acc), neg_main));
        quo_fix  = WIDTH'(cond_neg(FIX_BITS'(acc[WIDTH-1:0]), neg_main));
        rem_fix  = WIDTH'(cond_neg(FIX_BITS'(acc[PW-1:WIDTH]), neg_rem));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept_op  = 1'b0;
        accept_mtx = 1'b0;
        iter_step  = 1'b0;
        unique case (state)
            IDLE: begin
                accept_op  = start & ~op[2];
                accept_mtx = start & ((op == OP_MTHI) | (op == OP_MTLO));
                if (accept_op) state_next = CALC;
            end
            CALC: begin
                busy      = 1'b1;
                iter_step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand-side latches, iteration counter, HI/LO and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_mtx) begin
                if (op == OP_MTHI) hi <= rs_val;
                else               lo <= rs_val;
            end
            if (accept_op) begin
                cnt      <= '0;
                is_div   <= op[1];
                // Divide by zero keeps the all-ones quotient unnegated.
                neg_main <= (sign_a ^ sign_b) & ~(op[1] & (rt_val == '0));
                neg_rem  <= sign_a;
            end
            if (iter_step) cnt <= cnt + 1'b1;
            if (state == FIX) begin
                done <= 1'b1;
                if (is_div) begin
                    lo <= quo_fix;
                    hi <= rem_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_op),
        .step     (iter_step),
        .mode_div (is_div),
        .a        (a_mag),
        .b        (b_mag),
        .acc      (acc)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model tracks
// HI/LO, busy and done cycle by cycle; directed cases pin known results.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference model state.
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    logic [2*W-1:0] m_pend = '0;
    int             m_busy = 0;
    bit             m_done = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result as {hi, lo}, from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int q, r;
        case (o)
            3'd0: return longint'($signed(a)) * longint'($signed(b));
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs presented at it.
    task automatic model_step();
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                {m_hi, m_lo} = m_pend;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                m_pend = ref_result(op, rs_val, rt_val);
                m_busy = W + 1;
            end else if (op == 3'd4) begin
                m_hi = rs_val;
            end else if (op == 3'd5) begin
                m_lo = rs_val;
            end
        end
    endtask

    // Present inputs for one cycle; returns at the following falling edge.
    task automatic apply(input logic s, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        start = s; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, (m_busy > 0));
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Issue one op, wait for done, and pin the result and busy length.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input bit poke, input string name);
        int n = 0;
        bit seen = 1'b0;
        apply(1'b1, o, a, b);
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            if (poke && i == 0) apply(1'b1, 3'd5, 32'hDEAD_BEEF, '0);
            else                apply(1'b0, 3'd0, '0, '0);
        end
        check({name, " done seen"}, seen, 1'b1);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        check({name, " busy cycles"}, n, 33);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply(1'b0, 3'd0, '0, '0);
        apply(1'b0, 3'd0, '0, '0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        rst = 1'b0;
        checking = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "MULT -3*7");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "MULTU max");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "DIV -7/2");
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "DIVU 100/7");
        run_op(3'd3, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, 1'b0, "DIVU by zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "DIV overflow");
        run_op(3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1, "MULT with MTLO while busy");

        apply(1'b1, 3'd4, 32'h1234, '0);
        apply(1'b1, 3'd5, 32'h5678, '0);
        check("MTHI value", hi, 32'h1234);
        check("MTLO value", lo, 32'h5678);
        check("MTHI/MTLO no done", done, 1'b0);

        apply(1'b1, 3'd0, 32'h0001_2345, 32'h0000_0777);
        for (int i = 0; i < 9; i++) apply(1'b0, 3'd0, '0, '0);
        rst = 1'b1;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        check("async reset hi", hi, 32'h0);
        check("async reset lo", lo, 32'h0);
        apply(1'b0, 3'd0, '0, '0);
        apply(1'b1, 3'd0, 32'd3, 32'd3);
        rst = 1'b0;
        apply(1'b0, 3'd0, '0, '0);

        for (int c = 0; c < 2500; c++) begin
            apply(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), pick(), pick());
        end
        for (int c = 0; c < 40; c++) apply(1'b0, 3'd0, '0, '0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
